// File: rtl/memory_arbiter.sv
// memory_arbiter
// Two-port round-robin arbiter and sequencer for a single-port synchronous
// memory. Requests from two independent requesters are serialised into one
// memory access at a time. Each access is IDLE (grant) -> ACCESS -> DONE,
// so every access occupies three cycles.
//
// Ports
//   clk, rst_            clock, asynchronous active-low reset
//   req0/1, we0/1        level request and direction (1 = write), per requester
//   addr0/1, wdata0/1    request address and write data, stable while req high
//   ack0/1               one-cycle completion pulse (high in DONE)
//   rdata0/1             per-requester read data, updated on own read completion
//   busy                 high whenever the sequencer is not IDLE
//   mem_wr, mem_rd       memory strobes, high only during ACCESS
//   mem_addr             memory address, holds its last value outside ACCESS
//   mem_data             bidirectional bus, driven only during a write ACCESS
//
// state  | meaning
// IDLE   | waiting for a request; grant is made on the edge that leaves IDLE
// ACCESS | memory strobe active; read data captured on the closing edge
// DONE   | winner's ack high; returns to IDLE without sampling req

module memory_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              busy,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;      // requester served most recently
    logic                sel_q, sel_d;        // requester owning the current access
    logic                we_q, we_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                mem_wr_q, mem_wr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DWIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DWIDTH-1:0]   rdata1_q, rdata1_d;
    logic                grant;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mem_wr_d = 1'b0;
        mem_rd_d = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Lone requester wins; on a tie the one not served last wins.
                    grant    = (req0 && req1) ? ~last_q : req1;
                    last_d   = grant;
                    sel_d    = grant;
                    we_d     = grant ? we1 : we0;
                    addr_d   = grant ? addr1 : addr0;
                    wdata_d  = grant ? wdata1 : wdata0;
                    mem_wr_d = grant ? we1 : we0;
                    mem_rd_d = grant ? ~we1 : ~we0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (sel_q) begin
                    ack1_d = 1'b1;
                    if (!we_q) rdata1_d = mem_data;
                end else begin
                    ack0_d = 1'b1;
                    if (!we_q) rdata0_d = mem_data;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_wr_q <= mem_wr_d;
            mem_rd_q <= mem_rd_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // The write strobe is only ever high in ACCESS, so it doubles as the bus enable.
    assign mem_data = mem_wr_q ? wdata_q : {DWIDTH{1'bz}};

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q != IDLE);
    assign mem_wr   = mem_wr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    logic       clk;
    logic       rst_;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       busy, mem_wr, mem_rd;
    logic [4:0] mem_addr;
    wire  [7:0] mem_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_ack_cyc = 0;

    memory_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk(clk), .rst_(rst_),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // Memory model: synchronous write, combinational read while mem_rd is high.
    logic [7:0] mem_q [32];
    always @(posedge clk) if (mem_wr) mem_q[mem_addr] <= mem_data;
    assign mem_data = (mem_rd && !mem_wr) ? mem_q[mem_addr] : 8'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Per-cycle bus discipline and busy consistency.
    always @(negedge clk) begin
        chk("strobe_exclusive", {31'd0, mem_wr & mem_rd}, 32'd0);
        chk("busy_vs_activity", {31'd0, busy}, {31'd0, mem_wr | mem_rd | ack0 | ack1});
        chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
        if (!mem_wr && !mem_rd) begin
            checks++;
            if (!(mem_data === 8'bz || mem_data === 8'h00)) begin
                failures++;
                $display("FAIL bus_release actual=%0h required=z", mem_data);
            end
        end
    end

    typedef struct {
        bit         pre_reset;
        bit         r0;
        bit         w0;
        logic [4:0] a0;
        logic [7:0] d0;
        bit         r1;
        bit         w1;
        logic [4:0] a1;
        logic [7:0] d1;
        bit         exp_id;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
        int         exp_gap;
    } vec_t;

    // Applied at a negedge (normally the one where the previous ack was seen).
    task automatic run_vec(input vec_t v, input string nm);
        bit found;
        if (v.pre_reset) begin
            req0 = 1'b0; req1 = 1'b0;
            @(negedge clk);
            rst_ = 1'b0;
            @(negedge clk);
            rst_ = 1'b1;
            @(negedge clk);
        end
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (ack0 || ack1) found = 1'b1;
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_ack required=ack", nm);
        end else begin
            chk({nm, "_ack"}, {30'd0, ack1, ack0}, v.exp_id ? 32'd2 : 32'd1);
            chk({nm, "_rdata0"}, {24'd0, rdata0}, {24'd0, v.exp_r0});
            chk({nm, "_rdata1"}, {24'd0, rdata1}, {24'd0, v.exp_r1});
            if (v.exp_gap != 0)
                chk({nm, "_gap"}, cyc - last_ack_cyc, v.exp_gap);
            last_ack_cyc = cyc;
        end
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        tbl[0] = '{0, 1,1,5'h03,8'hA5, 0,0,5'h00,8'h00, 0, 8'h00,8'h00, 0};
        tbl[1] = '{0, 1,0,5'h03,8'h00, 0,0,5'h00,8'h00, 0, 8'hA5,8'h00, 3};
        tbl[2] = '{0, 0,0,5'h00,8'h00, 1,1,5'h1F,8'h77, 1, 8'hA5,8'h00, 3};
        tbl[3] = '{1, 1,1,5'h01,8'h11, 1,1,5'h02,8'h22, 0, 8'h00,8'h00, 0};
        tbl[4] = '{0, 1,0,5'h01,8'h00, 1,1,5'h02,8'h22, 1, 8'h00,8'h00, 3};
        tbl[5] = '{0, 1,0,5'h01,8'h00, 1,0,5'h02,8'h00, 0, 8'h11,8'h00, 3};
        tbl[6] = '{0, 0,0,5'h00,8'h00, 1,0,5'h02,8'h00, 1, 8'h11,8'h22, 3};

        rst_ = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_ = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Requester 1 sweep: write addr 31..1 with 0..30, then read back.
        for (int k = 0; k < 31; k++) begin
            v = '{0, 0,0,5'h00,8'h00, 1,1,5'(31-k),8'(k), 1, 8'h11,8'h22, 3};
            run_vec(v, $sformatf("sweep_wr%0d", k));
        end
        for (int k = 0; k < 31; k++) begin
            v = '{0, 0,0,5'h00,8'h00, 1,0,5'(31-k),8'h00, 1, 8'h11,8'(k), 3};
            run_vec(v, $sformatf("sweep_rd%0d", k));
            chk($sformatf("sweep_rd%0d_known", k), {31'd0, $isunknown(rdata1)}, 32'd0);
        end
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Reset dropped in the middle of a read access.
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h05;
        @(negedge clk);
        chk("mid_rst_pre_rd", {31'd0, mem_rd}, 32'd1);
        chk("mid_rst_pre_addr", {27'd0, mem_addr}, 32'h05);
        #2 rst_ = 1'b0;
        #1;
        chk("mid_rst_rd", {31'd0, mem_rd}, 32'd0);
        chk("mid_rst_acks", {30'd0, ack1, ack0}, 32'd0);
        chk("mid_rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        chk("mid_rst_noack", {30'd0, ack1, ack0}, 32'd0);
        rst_ = 1'b1;
        @(negedge clk);
        v = '{0, 1,0,5'h05,8'h00, 0,0,5'h00,8'h00, 0, 8'h1A,8'h00, 0};
        run_vec(v, "post_rst_rd");
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
